// File: rtl/fetch_mem_port.sv
// Instruction-side responder: tagged word buffer in front of a single-outstanding read bus.
// Define FETCH_PREFETCH_EN for a two-entry buffer with next-word prefetch.
module fetch_mem_port (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

`ifdef FETCH_PREFETCH_EN
  localparam int NE = 2;
`else
  localparam int NE = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [29:0]          req_tag_q, req_tag_d;
  logic [NE-1:0]        vld_q;
  logic [NE-1:0][29:0]  tag_q;
  logic [NE-1:0][31:0]  data_q;
  logic [NE-1:0]        hit_vec;
  logic [29:0]          ftag;
  logic                 fill;
  logic                 victim;
  logic                 unused_lsb;

  assign ftag       = fetch_addr[31:2];
  assign unused_lsb = ^fetch_addr[1:0];

  always_comb begin
    fetch_data = '0;
    for (int i = 0; i < NE; i++) begin
      hit_vec[i] = vld_q[i] && (tag_q[i] == ftag);
      if (hit_vec[i]) fetch_data = fetch_data | data_q[i];
    end
  end
  assign fetch_valid = |hit_vec;

`ifdef FETCH_PREFETCH_EN
  logic        lru_q;
  logic        nxt_hit;
  logic [29:0] nxt_tag;

  // Tag arithmetic is 30 bits wide, so the last word wraps to tag 0.
  assign nxt_tag = ftag + 30'd1;
  always_comb begin
    nxt_hit = 1'b0;
    for (int i = 0; i < NE; i++)
      if (vld_q[i] && (tag_q[i] == nxt_tag)) nxt_hit = 1'b1;
  end

  // Keep the word the fetch stage is looking at; otherwise evict the older fill.
  assign victim = hit_vec[0] ? 1'b1 : (hit_vec[1] ? 1'b0 : lru_q);

  always_ff @(posedge clk) begin
    if (!resetn)   lru_q <= 1'b0;
    else if (fill) lru_q <= ~victim;
  end
`else
  assign victim = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    fill      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fetch_valid) begin
          req_tag_d = ftag;
          state_d   = S_REQ;
        end
`ifdef FETCH_PREFETCH_EN
        else if (!nxt_hit) begin
          req_tag_d = nxt_tag;
          state_d   = S_REQ;
        end
`endif
      end
      S_REQ:  if (mem_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = mem_req ? {req_tag_q, 2'b00} : 32'd0;

  // A reset abandons any in-flight read; its late response lands in IDLE and is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      req_tag_q <= '0;
      vld_q     <= '0;
      tag_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_tag_q <= req_tag_d;
      for (int i = 0; i < NE; i++) begin
        if (fill && (victim == 1'(i))) begin
          vld_q[i]  <= 1'b1;
          tag_q[i]  <= req_tag_q;
          data_q[i] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_port.sv
// Directed bench for fetch_mem_port; covers the prefetch build when FETCH_PREFETCH_EN is defined.
module tb_fetch_mem_port;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_mem_port dut (
    .clk(clk), .resetn(resetn),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are then applied and checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef FETCH_PREFETCH_EN
  // Reset, demand-miss addr with zero-wait memory, then expect the automatic prefetch.
  task automatic pf_seq(input logic [31:0] addr, input logic [31:0] pf_addr, input logic [31:0] d);
    resetn = 1'b0; fetch_addr = addr; mem_ready = 1'b1; mem_rvalid = 1'b0;
    tick(); tick();
    resetn = 1'b1; #1;
    chk("pf_miss_valid", {31'd0, fetch_valid}, 32'd0);
    tick(); #1;
    chk("pf_dem_addr", mem_addr, addr);
    tick(); mem_rvalid = 1'b1; mem_rdata = d; #1;
    tick(); mem_rvalid = 1'b0; #1;
    chk("pf_hit_valid", {31'd0, fetch_valid}, 32'd1);
    chk("pf_hit_data", fetch_data, d);
    tick(); #1;
    chk("pf_req", {31'd0, mem_req}, 32'd1);
    chk("pf_addr", mem_addr, pf_addr);
    tick(); mem_rvalid = 1'b1; mem_rdata = ~d; #1;
    tick(); mem_rvalid = 1'b0; fetch_addr = pf_addr; #1;
    chk("pf_next_valid", {31'd0, fetch_valid}, 32'd1);
    chk("pf_next_data", fetch_data, ~d);
  endtask
`endif

  initial begin
    resetn = 1'b0; fetch_addr = 32'h100; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick(); #1;
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_req",   {31'd0, mem_req},     32'd0);
    chk("rst_addr",  mem_addr,             32'd0);
    chk("rst_data",  fetch_data,           32'd0);

`ifndef FETCH_PREFETCH_EN
    // Basic miss: N, N+1 REQ, N+2 WAIT/fill, N+3 valid
    resetn = 1'b1; mem_ready = 1'b1; #1;
    chk("m1_n_valid", {31'd0, fetch_valid}, 32'd0);
    tick(); #1;
    chk("m1_req",  {31'd0, mem_req}, 32'd1);
    chk("m1_addr", mem_addr, 32'h100);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h13; #1;
    chk("m1_wait_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_rvalid = 1'b0; #1;
    chk("m1_valid", {31'd0, fetch_valid}, 32'd1);
    chk("m1_data",  fetch_data, 32'h13);
    chk("m1_noreq", {31'd0, mem_req}, 32'd0);
    fetch_addr = 32'h102; #1;
    chk("mis_valid", {31'd0, fetch_valid}, 32'd1);
    chk("mis_data",  fetch_data, 32'h13);

    // Stalled request: ready low for 4 cycles
    tick(); fetch_addr = 32'h200; mem_ready = 1'b0; #1;
    chk("st_n_valid", {31'd0, fetch_valid}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) mem_ready = 1'b1;
      #1;
      chk("st_req",  {31'd0, mem_req}, 32'd1);
      chk("st_addr", mem_addr, 32'h200);
      chk("st_nvld", {31'd0, fetch_valid}, 32'd0);
    end
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA0200; #1;
    tick(); mem_rvalid = 1'b0; #1;
    chk("st_valid", {31'd0, fetch_valid}, 32'd1);
    chk("st_data",  fetch_data, 32'hAAAA0200);

    // Redirect while waiting for 0x300
    tick(); fetch_addr = 32'h300; mem_ready = 1'b1; #1;
    tick(); #1;
    chk("rd_addr300", mem_addr, 32'h300);
    tick(); fetch_addr = 32'h400; #1;
    chk("rd_nvld_wait", {31'd0, fetch_valid}, 32'd0);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0300CAFE; #1;
    chk("rd_nvld_fill", {31'd0, fetch_valid}, 32'd0);
    tick(); mem_rvalid = 1'b0; #1;
    chk("rd_nvld_idle", {31'd0, fetch_valid}, 32'd0);
    chk("rd_idle_req",  {31'd0, mem_req}, 32'd0);
    tick(); fetch_addr = 32'h300; #1;
    chk("rd_req400",  {31'd0, mem_req}, 32'd1);
    chk("rd_addr400", mem_addr, 32'h400);
    chk("rd_hit300",  {31'd0, fetch_valid}, 32'd1);
    chk("rd_data300", fetch_data, 32'h0300CAFE);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0400BEEF; #1;
    tick(); mem_rvalid = 1'b0; fetch_addr = 32'h400; #1;
    chk("rd_hit400",  {31'd0, fetch_valid}, 32'd1);
    chk("rd_data400", fetch_data, 32'h0400BEEF);

    // Reset in WAIT, then a late rvalid
    tick(); fetch_addr = 32'h500; #1;
    tick(); #1;
    chk("rw_addr500", mem_addr, 32'h500);
    tick(); resetn = 1'b0; #1;
    tick(); resetn = 1'b1; fetch_addr = 32'h400; mem_rvalid = 1'b1; mem_rdata = 32'hDEADDEAD; #1;
    chk("rw_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rw_req",   {31'd0, mem_req}, 32'd0);
    chk("rw_data",  fetch_data, 32'd0);
    tick(); mem_rvalid = 1'b0; #1;
    chk("rw_late_nvld", {31'd0, fetch_valid}, 32'd0);
    chk("rw_req400",    {31'd0, mem_req}, 32'd1);
    chk("rw_addr400",   mem_addr, 32'h400);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h44; #1;
    tick(); mem_rvalid = 1'b0; #1;
    chk("rw_valid400", {31'd0, fetch_valid}, 32'd1);
    chk("rw_data400",  fetch_data, 32'h44);

    // Misaligned miss is requested word-aligned
    tick(); fetch_addr = 32'h506; #1;
    tick(); #1;
    chk("ma_addr", mem_addr, 32'h504);
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h5555; #1;
    tick(); mem_rvalid = 1'b0; fetch_addr = 32'h507; #1;
    chk("ma_valid", {31'd0, fetch_valid}, 32'd1);
    chk("ma_data",  fetch_data, 32'h5555);
    tick(); #1;
    chk("ma_noreq", {31'd0, mem_req}, 32'd0);
`else
    pf_seq(32'h0, 32'h4, 32'h00000013);
    pf_seq(32'hFFFFFFFC, 32'h0, 32'h12345678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
